led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised LED pattern generator, the next-generation LED sequencer for the board LED bank. A single-clock design: a clock-enable prescaler replaces derived clocks and asynchronous control inputs. It drives N_LED outputs through four selectable patterns, either fixed or auto-cycling, at two speeds. Its outputs connect directly to the LED pins, and a status side-band goes to the debug display.

## Interface
- N_LED, 16, number of LEDs; even, ≥ 4
- FAST_DIV, 10, prescaler terminal count when speed=0; ≥ 1
- SLOW_DIV, 40, prescaler terminal count when speed=1; ≥ 1
- ACTIVE_LOW, 1, 1: led bit 0 = lit; 0: led bit 1 = lit
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- speed  input  1  0 = fast (FAST_DIV), 1 = slow (SLOW_DIV)
- run  input  1  1 = sequence patterns; 0 = blank and hold at start
- auto_cycle  input  1  1 = advance to next pattern after last step; 0 = repeat current pattern
- mode_sel  input  2  pattern chosen when auto_cycle=0, and on run restart
- led  output  N_LED  registered LED drive
- step_tick  output  1  one-cycle pulse, coincident with every led update
- pat_id  output  2  pattern currently displayed
- step_idx  output  $clog2(N_LED)  step currently displayed

## Operation
- Internal lit-mask M (1 = lit). Output rule: led = ACTIVE_LOW ? ~M : M. "All off" means M = 0.
- Patterns, with step k:
  - 0 SHIFT: N_LED steps; bit N_LED-1-k lit.
  - 1 CONVERGE: N_LED/2 steps; bits N_LED-1-k and k lit.
  - 2 CONVERGE2: N_LED/2 steps; bits N_LED-1-k, N_LED-2-k, k and k+1 lit. Overlapping bits are simply lit.
  - 3 DIVERGE: N_LED/2 steps; bits N_LED/2-1-k and N_LED/2+k lit.
- Prescaler: cnt counts 0..DIV, where DIV is selected by speed. tick is high when cnt==DIV; cnt then returns to 0. Tick period is DIV+1 cycles.
- On tick with run=1:
  - led is loaded with the mask of (pat, step), and step_tick pulses.
  - If step is the last step of pat: step→0. pat→(pat+1) mod 4 if auto_cycle=1; otherwise pat→mode_sel.
  - Else: step→step+1. If auto_cycle=0 and mode_sel≠pat, then pat→mode_sel and step→0. The new pattern is displayed from step 0 on the following tick.
- pat_id and step_idx are updated together with led, and reflect the values just displayed.
- run=0 (synchronous): next edge sets led all off, cnt→0, step→0, pat→mode_sel. step_tick stays 0. pat_id and step_idx hold.
- Speed change: speed is registered. When the registered value differs from the live input, cnt→0 that cycle and no tick occurs. The new period starts from 0.
- Reset (async assert, sync release):
  - cnt=0, pat=0, step=0.
  - led all off (all ones if ACTIVE_LOW=1, else all zeros).
  - step_tick=0, pat_id=0, step_idx=0.
- Simultaneous events: run=0 overrides tick. Reset overrides everything.

## Timing
- From run rising (cnt=0), the first tick comes DIV+1 cycles later. led shows step 0 on the edge after tick, together with step_tick.
- Steady state: led changes exactly every DIV+1 cycles: 11 cycles fast, 41 cycles slow (defaults).
- Full cycle with auto_cycle=1 and default N_LED is 16+8+8+8 = 40 ticks, then it wraps to SHIFT step 0.
- step_tick is high for exactly one cycle per update and never high while run=0.
- Control input changes take effect at the next clk edge. There are no asynchronous paths except rst.

## Test plan
- Reset: hold rst=0 with clk running → led=16'hFFFF, step_tick=0, pat_id=0, step_idx=0. Release with run=1, speed=0, auto_cycle=0, mode_sel=0. First step_tick comes 11 cycles later with led=16'h7FFF, then 16'hBFFF 11 cycles after that.
- Slow speed: speed=1, mode_sel=1 → step_tick spacing is 41 cycles. led sequence is 16'h7FFE, 16'hBFFD … 16'hFE7F, then wraps to 16'h7FFE.
- Auto cycle: auto_cycle=1, speed=0 → after SHIFT step 15 (16'hFFFE), next led is 16'h7FFE (pat_id=1). After DIVERGE step 7 (16'h7FFE), next is 16'h7FFF (pat_id=0). Period between SHIFT step 0 occurrences is 440 cycles.
- Run drop mid-pattern: deassert run at SHIFT step 5 → led=16'hFFFF on next edge and no step_tick. Re-assert run → first update 11 cycles later with led=16'h7FFF (step 0).
- Speed change mid-count: switch speed 0→1 when cnt=7 → no tick. The next step_tick comes 42 cycles after the switch edge (1 cycle to clear cnt, then 41).
- Async reset mid-operation: pulse rst low between clk edges during pattern 2 → led=16'hFFFF immediately, with no clk edge needed. Sequencing restarts at SHIFT step 0. Repeat with ACTIVE_LOW=0 and N_LED=8 → reset led=8'h00, first update 8'h80.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern sequencer: a clock-enable prescaler steps one of four lit-mask
// patterns onto the LED bank, with fixed or auto-cycling pattern selection.
module led_pattern_gen #(
    parameter int N_LED      = 16,
    parameter int FAST_DIV   = 10,
    parameter int SLOW_DIV   = 40,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     speed,
    input  logic                     run,
    input  logic                     auto_cycle,
    input  logic [1:0]               mode_sel,
    output logic [N_LED-1:0]         led,
    output logic                     step_tick,
    output logic [1:0]               pat_id,
    output logic [$clog2(N_LED)-1:0] step_idx
);

    localparam int SW      = $clog2(N_LED);
    localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int CW      = $clog2(MAX_DIV + 1);

    localparam logic [SW-1:0]    LAST_SHIFT = SW'(N_LED - 1);
    localparam logic [SW-1:0]    LAST_HALF  = SW'(N_LED / 2 - 1);
    localparam logic [N_LED-1:0] ONE        = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED-1:0] LED_OFF    = ACTIVE_LOW ? {N_LED{1'b1}} : {N_LED{1'b0}};

    typedef enum logic [1:0] {
        PAT_SHIFT     = 2'd0,
        PAT_CONVERGE  = 2'd1,
        PAT_CONVERGE2 = 2'd2,
        PAT_DIVERGE   = 2'd3
    } pat_t;

    // Lit-mask (1 = lit) for a pattern at a given step.
    function automatic logic [N_LED-1:0] f_mask(input pat_t pat, input logic [SW-1:0] step);
        logic [N_LED-1:0] m;
        int               k;
        k = int'(step);
        case (pat)
            PAT_SHIFT:     m = ONE << (N_LED - 1 - k);
            PAT_CONVERGE:  m = (ONE << (N_LED - 1 - k)) | (ONE << k);
            PAT_CONVERGE2: m = (ONE << (N_LED - 1 - k)) | (ONE << (N_LED - 2 - k))
                             | (ONE << k) | (ONE << (k + 1));
            default:       m = (ONE << (N_LED / 2 - 1 - k)) | (ONE << (N_LED / 2 + k));
        endcase
        return m;
    endfunction

    logic             r_speed;
    logic [CW-1:0]    r_cnt;
    pat_t             r_pat;
    logic [SW-1:0]    r_step;
    logic [N_LED-1:0] r_led;
    logic             r_step_tick;
    logic [1:0]       r_pat_id;
    logic [SW-1:0]    r_step_idx;

    logic [CW-1:0]    w_div;
    logic             w_last;
    pat_t             w_sel;
    logic [N_LED-1:0] w_mask;
    logic [N_LED-1:0] w_drive;

    assign w_div   = r_speed ? CW'(SLOW_DIV) : CW'(FAST_DIV);
    assign w_last  = (r_pat == PAT_SHIFT) ? (r_step == LAST_SHIFT) : (r_step == LAST_HALF);
    assign w_sel   = pat_t'(mode_sel);
    assign w_mask  = f_mask(r_pat, r_step);
    assign w_drive = ACTIVE_LOW ? ~w_mask : w_mask;

    // run=0 wins over a tick; a speed change restarts the prescaler without ticking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_speed     <= 1'b0;
            r_cnt       <= '0;
            r_pat       <= PAT_SHIFT;
            r_step      <= '0;
            r_led       <= LED_OFF;
            r_step_tick <= 1'b0;
            r_pat_id    <= 2'd0;
            r_step_idx  <= '0;
        end else begin
            r_speed     <= speed;
            r_step_tick <= 1'b0;
            if (!run) begin
                r_led  <= LED_OFF;
                r_cnt  <= '0;
                r_step <= '0;
                r_pat  <= w_sel;
            end else if (r_speed != speed) begin
                r_cnt <= '0;
            end else if (r_cnt == w_div) begin
                r_cnt       <= '0;
                r_led       <= w_drive;
                r_step_tick <= 1'b1;
                r_pat_id    <= r_pat;
                r_step_idx  <= r_step;
                if (w_last) begin
                    r_step <= '0;
                    r_pat  <= auto_cycle ? pat_t'(r_pat + 2'd1) : w_sel;
                end else if (!auto_cycle && (w_sel != r_pat)) begin
                    r_step <= '0;
                    r_pat  <= w_sel;
                end else begin
                    r_step <= r_step + 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign led       = r_led;
    assign step_tick = r_step_tick;
    assign pat_id    = r_pat_id;
    assign step_idx  = r_step_idx;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed timing/pattern checks plus
// randomized control segments compared every cycle against a behavioural model.
module tb_led_pattern_gen;

    localparam int N    = 16;
    localparam int FAST = 10;
    localparam int SLOW = 40;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, speed, run, auto_cycle;
    logic [1:0]  mode_sel;
    logic [15:0] led;
    logic        step_tick;
    logic [1:0]  pat_id;
    logic [3:0]  step_idx;

    logic        rst2;
    logic [7:0]  led2;
    logic        step_tick2;
    logic [1:0]  pat_id2;
    logic [2:0]  step_idx2;

    led_pattern_gen #(.N_LED(N), .FAST_DIV(FAST), .SLOW_DIV(SLOW), .ACTIVE_LOW(1'b1)) u_dut (
        .clk(clk), .rst(rst), .speed(speed), .run(run), .auto_cycle(auto_cycle),
        .mode_sel(mode_sel), .led(led), .step_tick(step_tick), .pat_id(pat_id),
        .step_idx(step_idx)
    );

    led_pattern_gen #(.N_LED(8), .FAST_DIV(FAST), .SLOW_DIV(SLOW), .ACTIVE_LOW(1'b0)) u_dut2 (
        .clk(clk), .rst(rst2), .speed(1'b0), .run(1'b1), .auto_cycle(1'b0),
        .mode_sel(2'd0), .led(led2), .step_tick(step_tick2), .pat_id(pat_id2),
        .step_idx(step_idx2)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // behavioural reference model (16 LEDs, active-low drive)
    typedef struct {
        int          cnt;
        int          pat;
        int          step;
        logic [15:0] led;
        logic        tick;
        int          pat_id;
        int          step_idx;
        logic        spd;
    } mstate_t;

    mstate_t m;

    function automatic int nsteps(input int p);
        return (p == 0) ? N : N / 2;
    endfunction

    function automatic logic [15:0] ref_mask(input int p, input int k);
        logic [31:0] v;
        case (p)
            0:       v = 32'd1 << (N - 1 - k);
            1:       v = (32'd1 << (N - 1 - k)) | (32'd1 << k);
            2:       v = (32'd1 << (N - 1 - k)) | (32'd1 << (N - 2 - k)) | (32'd1 << k) | (32'd1 << (k + 1));
            default: v = (32'd1 << (N / 2 - 1 - k)) | (32'd1 << (N / 2 + k));
        endcase
        return v[15:0];
    endfunction

    function automatic mstate_t model_reset();
        mstate_t s;
        s.cnt = 0; s.pat = 0; s.step = 0; s.led = 16'hFFFF; s.tick = 1'b0;
        s.pat_id = 0; s.step_idx = 0; s.spd = 1'b0;
        return s;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic spd_in, input logic run_in,
                                           input logic auto_in, input int sel);
        mstate_t n;
        int      period_end;
        n          = s;
        period_end = s.spd ? SLOW : FAST;
        n.tick     = 1'b0;
        n.spd      = spd_in;
        if (!run_in) begin
            n.led = 16'hFFFF; n.cnt = 0; n.step = 0; n.pat = sel;
        end else if (s.spd != spd_in) begin
            n.cnt = 0;
        end else if (s.cnt == period_end) begin
            n.cnt      = 0;
            n.led      = ~ref_mask(s.pat, s.step);
            n.tick     = 1'b1;
            n.pat_id   = s.pat;
            n.step_idx = s.step;
            if (s.step == nsteps(s.pat) - 1) begin
                n.step = 0;
                n.pat  = auto_in ? (s.pat + 1) % 4 : sel;
            end else if (!auto_in && sel != s.pat) begin
                n.step = 0;
                n.pat  = sel;
            end else begin
                n.step = s.step + 1;
            end
        end else begin
            n.cnt = s.cnt + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= model_reset();
        else      m <= model_next(m, speed, run, auto_cycle, int'(mode_sel));
    end

    // scoreboard: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("led", {16'h0, led}, {16'h0, m.led});
            check("step_tick", {31'h0, step_tick}, {31'h0, m.tick});
            check("pat_id", {30'h0, pat_id}, m.pat_id);
            check("step_idx", {28'h0, step_idx}, m.step_idx);
        end
    end

    // driver: wait for the next step_tick (returns at a negedge)
    task automatic wait_tick(input bit sel2, input int budget, output int cycles);
        logic tk;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            tk = sel2 ? step_tick2 : step_tick;
        end while (tk !== 1'b1 && cycles < budget);
        check("tick_seen", {31'h0, tk}, 32'd1);
    endtask

    int c;
    int total;
    int prev_pat, prev_step;

    initial begin
        rst = 1'b0; rst2 = 1'b0;
        speed = 1'b0; run = 1'b1; auto_cycle = 1'b0; mode_sel = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_led", {16'h0, led}, 32'hFFFF);
        check("rst_tick", {31'h0, step_tick}, 32'd0);
        check("rst_pat", {30'h0, pat_id}, 32'd0);
        check("rst_step", {28'h0, step_idx}, 32'd0);
        check("rst2_led", {24'h0, led2}, 32'h00);
        chk_en = 1'b1;
        rst = 1'b1;

        wait_tick(0, 20, c);
        check("first_lat", c, 32'd11);
        check("first_led", {16'h0, led}, 32'h7FFF);
        wait_tick(0, 20, c);
        check("second_lat", c, 32'd11);
        check("second_led", {16'h0, led}, 32'hBFFF);

        // slow speed, CONVERGE
        speed = 1'b1; mode_sel = 2'd1;
        for (int i = 0; i < 30 && !(pat_id == 2'd1 && step_idx == 4'd0); i++) wait_tick(0, 100, c);
        check("slow_s0_led", {16'h0, led}, 32'h7FFE);
        wait_tick(0, 100, c);
        check("slow_period", c, 32'd41);
        check("slow_s1_led", {16'h0, led}, 32'hBFFD);
        for (int i = 0; i < 6; i++) wait_tick(0, 100, c);
        check("slow_s7_led", {16'h0, led}, 32'hFE7F);
        wait_tick(0, 100, c);
        check("slow_wrap_led", {16'h0, led}, 32'h7FFE);

        // auto cycle, fast
        auto_cycle = 1'b1; speed = 1'b0;
        for (int i = 0; i < 60 && !(pat_id == 2'd0 && step_idx == 4'd0); i++) wait_tick(0, 100, c);
        total = 0;
        prev_pat = 0; prev_step = 0;
        for (int i = 0; i < 40; i++) begin
            wait_tick(0, 100, c);
            total += c;
            if (prev_pat == 0 && prev_step == 15) begin
                check("auto_shift_end_led", {16'h0, led}, 32'h7FFE);
                check("auto_shift_end_pat", {30'h0, pat_id}, 32'd1);
            end
            if (prev_pat == 3 && prev_step == 7) begin
                check("auto_div_end_led", {16'h0, led}, 32'h7FFF);
                check("auto_div_end_pat", {30'h0, pat_id}, 32'd0);
            end
            prev_pat = int'(pat_id); prev_step = int'(step_idx);
        end
        check("auto_full_cycle", total, 32'd440);
        check("auto_wrap_step", {28'h0, step_idx}, 32'd0);

        // run drop mid-pattern
        auto_cycle = 1'b0; mode_sel = 2'd0;
        for (int i = 0; i < 80 && !(pat_id == 2'd0 && step_idx == 4'd5); i++) wait_tick(0, 100, c);
        run = 1'b0;
        @(negedge clk);
        check("drop_led", {16'h0, led}, 32'hFFFF);
        check("drop_tick", {31'h0, step_tick}, 32'd0);
        check("drop_step_hold", {28'h0, step_idx}, 32'd5);
        repeat (5) @(negedge clk);
        run = 1'b1;
        wait_tick(0, 20, c);
        check("rerun_lat", c, 32'd11);
        check("rerun_led", {16'h0, led}, 32'h7FFF);

        // speed change with cnt=7
        repeat (7) @(negedge clk);
        speed = 1'b1;
        wait_tick(0, 100, c);
        check("speed_chg_lat", c, 32'd42);

        // async reset during CONVERGE2
        speed = 1'b0; mode_sel = 2'd2;
        for (int i = 0; i < 60 && pat_id != 2'd2; i++) wait_tick(0, 100, c);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_led", {16'h0, led}, 32'hFFFF);
        check("async_rst_pat", {30'h0, pat_id}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_tick(0, 20, c);
        check("post_rst_lat", c, 32'd11);
        check("post_rst_led", {16'h0, led}, 32'h7FFF);

        // randomized control segments
        for (int seg = 0; seg < 40; seg++) begin
            run        = ($urandom_range(0, 7) != 0);
            speed      = 1'($urandom_range(0, 1));
            auto_cycle = 1'($urandom_range(0, 1));
            mode_sel   = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 120)) @(negedge clk);
        end

        // 8 LEDs, active-high drive
        check("dut2_rst_led", {24'h0, led2}, 32'h00);
        rst2 = 1'b1;
        wait_tick(1, 20, c);
        check("dut2_first_lat", c, 32'd11);
        check("dut2_first_led", {24'h0, led2}, 32'h80);
        wait_tick(1, 20, c);
        check("dut2_second_led", {24'h0, led2}, 32'h40);
        check("dut2_step_idx", {29'h0, step_idx2}, 32'd1);
        @(posedge clk);
        #2 rst2 = 1'b0;
        #1;
        check("dut2_async_rst_led", {24'h0, led2}, 32'h00);
        @(negedge clk);
        rst2 = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
